// File: rtl/hamming_pkg.sv
// Shared types and defaults for the Hamming serializer datapath.
package hamming_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int DEF_W = 32;
  localparam int DEF_N = 16000;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hamming_hold_reg.sv
// One-entry valid/ready holding register for an A/B word pair.
// Not flow-through: accepts only when empty; clr wins over a same-cycle push.
module hamming_hold_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b
);

  logic         vld_q, vld_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;

  always_comb begin
    vld_d = vld_q;
    a_d   = a_q;
    b_d   = b_q;
    if (out_rdy) vld_d = 1'b0;
    if (in_vld && in_rdy) begin
      vld_d = 1'b1;
      a_d   = in_a;
      b_d   = in_b;
    end
    if (clr) vld_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      vld_q <= vld_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  assign in_rdy  = !vld_q;
  assign out_vld = vld_q;
  assign out_a   = a_q;
  assign out_b   = b_q;

endmodule

// File: rtl/hamming_bit_serializer.sv
// Serializes A/B word pairs LSB-first, one bit pair per cycle, for exactly N
// bits per run; bubbles are driven as x=y=0 so they read as matches downstream.
module hamming_bit_serializer
  import hamming_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int N     = DEF_N,
  parameter int CNT_W = cnt_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             x,
  output logic             y,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bits_sent
);

  localparam int SC_W = $clog2(W + 1);

  state_e           state_q, state_d;
  logic [W-1:0]     sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [SC_W-1:0]  sh_cnt_q, sh_cnt_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic             x_q, x_d, y_q, y_d, bv_q, bv_d;

  logic             hold_rdy, hold_vld, hold_push, hold_pop, hold_clr;
  logic [W-1:0]     hold_a, hold_b;
  logic             run, emit, fin, sh_free, accept;

  hamming_hold_reg #(.W(W)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .clr     (hold_clr),
    .in_vld  (hold_push),
    .in_rdy  (hold_rdy),
    .in_a    (in_a),
    .in_b    (in_b),
    .out_vld (hold_vld),
    .out_rdy (hold_pop),
    .out_a   (hold_a),
    .out_b   (hold_b)
  );

  assign run      = (state_q == RUN);
  assign in_ready = run && hold_rdy;
  assign accept   = in_valid && in_ready;
  assign emit     = run && (sh_cnt_q != '0);
  assign fin      = emit && (bits_q == CNT_W'(N - 1));
  // The shifter can take a new word when empty or when its last bit leaves now.
  assign sh_free  = (sh_cnt_q == '0) || (emit && (sh_cnt_q == SC_W'(1)));

  always_comb begin
    state_d   = state_q;
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    sh_cnt_d  = sh_cnt_q;
    bits_d    = bits_q;
    x_d       = 1'b0;
    y_d       = 1'b0;
    bv_d      = 1'b0;
    hold_push = 1'b0;
    hold_pop  = 1'b0;
    hold_clr  = 1'b0;
    if (start) begin
      state_d  = RUN;
      sh_a_d   = '0;
      sh_b_d   = '0;
      sh_cnt_d = '0;
      bits_d   = '0;
      hold_clr = 1'b1;
    end else if (run) begin
      if (emit) begin
        x_d      = sh_a_q[0];
        y_d      = sh_b_q[0];
        bv_d     = 1'b1;
        sh_a_d   = sh_a_q >> 1;
        sh_b_d   = sh_b_q >> 1;
        sh_cnt_d = sh_cnt_q - SC_W'(1);
        bits_d   = bits_q + CNT_W'(1);
      end
      if (fin) begin
        // Leftover bits of the final word and any held word are dropped.
        state_d  = DONE;
        sh_cnt_d = '0;
        hold_clr = 1'b1;
      end else if (sh_free && hold_vld) begin
        sh_a_d   = hold_a;
        sh_b_d   = hold_b;
        sh_cnt_d = SC_W'(W);
        hold_pop = 1'b1;
      end else if (sh_free && accept) begin
        sh_a_d   = in_a;
        sh_b_d   = in_b;
        sh_cnt_d = SC_W'(W);
      end else begin
        hold_push = accept;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      sh_cnt_q <= '0;
      bits_q   <= '0;
      x_q      <= 1'b0;
      y_q      <= 1'b0;
      bv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      sh_cnt_q <= sh_cnt_d;
      bits_q   <= bits_d;
      x_q      <= x_d;
      y_q      <= y_d;
      bv_q     <= bv_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign bit_valid = bv_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign bits_sent = bits_q;

endmodule

// File: doc/hamming_bit_serializer.md
Name: hamming_bit_serializer

Overview:
Upstream feeder for the sequential Hamming accumulator.
- Accepts W-bit operand word pairs over a valid/ready handshake.
- Emits them LSB-first, one bit pair per cycle, on x/y.
- Stops after exactly N bit pairs per run and flags completion, so the accumulator's count can be sampled.
- Drives x=y=0 whenever no bit is available. Bubbles are matches and do not perturb the distance.

Parameters:
W, 32, operand word width in bits (>=2)
N, 16000, total bit pairs per run (>=1; need not be a multiple of W)
CNT_W, $clog2(N+1), width of bits_sent

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins (or restarts) a run
in_valid  in  1  word pair offered
in_ready  out  1  word pair accepted when in_valid && in_ready
in_a  in  W  operand A word
in_b  in  W  operand B word
x  out  1  serial bit of A (registered)
y  out  1  serial bit of B (registered)
bit_valid  out  1  x/y carry a real bit this cycle
busy  out  1  state==RUN
done  out  1  held high after N bits, until next start
bits_sent  out  CNT_W  bit pairs emitted in current run

Behaviour:
- Reset (rst=0, async): state IDLE; x=y=bit_valid=busy=done=in_ready=0; bits_sent=0; shifter and holding register empty.
- Internal storage:
  - Shift register pair with a remaining-bit count.
  - One-entry holding register (hold_valid).
- States:
  - IDLE: in_ready=0, outputs 0. start -> RUN; bits_sent, shifter and holder are cleared.
  - RUN: in_ready = !hold_valid. An accepted word goes to the holder, or directly to the shifter if the shifter is empty or its last bit goes out this cycle.
  - DONE: done=1, in_ready=0, x=y=bit_valid=0. start -> RUN with full clear. Any held word is discarded.
- Emission:
  - Each RUN cycle with a non-empty shifter drives x=A[0], y=B[0] and bit_valid=1 on the next edge, then shifts right and increments bits_sent.
  - An empty shifter gives a bubble: x=y=bit_valid=0.
- Latency: a word accepted at edge t into an empty shifter presents bit 0 after edge t+1.
- Refill: when the last bit of a word is emitted, the holder (or a concurrent accept) loads in the same cycle. Sustained throughput is 1 bit/cycle with no bubbles if a word arrives at least once per W cycles.
- Termination:
  - When bits_sent reaches N (on the edge emitting bit N), go to DONE on that edge.
  - The final partial word's unused upper bits are discarded.
  - bits_sent saturates at N.
- start in RUN aborts the run: full clear, stay in RUN, bits_sent=0. The next cycle is a bubble.
- start and in_valid in the same cycle from IDLE/DONE: the word is not accepted, because in_ready=0 that cycle.
- in_a/in_b may change freely while in_valid=0. Once offered, the payload must be held until accepted (upstream rule; the bench asserts it).

Decomposition:
- Shared package hamming_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - default W/N localparams
  - a function computing CNT_W
- One natural sub-module: hamming_hold_reg, the one-entry valid/ready holding register with W-bit A/B payload. It is reused by the result-capture stage.

Test Plan:
- W=8, N=16; rst low mid-run at bit 5 -> all outputs 0 immediately (async); after release, state IDLE and bits_sent=0.
- W=8, N=16; start, then two words A=0xFF/B=0x00 back-to-back with in_valid held -> bit_valid high 16 consecutive cycles, x=1,y=0 each; done rises on the edge of bit 16; accumulator reads 16.
- W=8, N=20; words A=0xA5/B=0x5A, 0x0F/0x0F, 0x03/0x00 -> exactly 20 bits emitted; third word contributes bits 0..3 only; accumulator reads 8+0+2=10.
- W=8, N=16; second word delayed 5 cycles -> 5 bubble cycles (x=y=bit_valid=0) between bit 8 and bit 9; final count unchanged.
- W=8, N=16; start pulsed again at bit 6 -> bits_sent=0 next cycle, holder cleared, in_ready=1; a new run of 16 bits completes normally.
- After done, offer in_valid=1 for 10 cycles -> in_ready stays 0, x/y stay 0, done stays 1 until start.
